// File: rtl/seq_det_pkg.sv
// ----------------------------------------------------------------------------
// seq_det_pkg
//
// Shared definitions for the programmable serial pattern detector.
// The power-up configuration is a non-overlapping "1010" detector, the same
// behaviour as the fixed 4-bit Mealy detectors this block replaces.
//
// Contents:
//   DEF_PATTERN  - reset pattern (zero-extended to MAX_LEN by the user)
//   DEF_LEN      - reset pattern length
//   DEF_OVERLAP  - reset overlap mode (0 = non-overlapping)
//   len_legal()  - legality check for a requested pattern length
// ----------------------------------------------------------------------------
package seq_det_pkg;

   localparam logic [3:0] DEF_PATTERN = 4'b1010;
   localparam int         DEF_LEN     = 4;
   localparam logic       DEF_OVERLAP = 1'b0;

   // A length is legal when it selects at least one bit and does not exceed
   // the physical window size.
   function automatic logic len_legal(input int len, input int max_len);
      return (len >= 1) && (len <= max_len);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
//
// Up-counter that holds at all-ones instead of wrapping.
//
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous, active-high; clears the count
//   clr    - synchronous clear (priority over inc)
//   inc    - increment by one unless already saturated
//   q      - current count
// ----------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] q_reg;
   logic [W-1:0] q_next;

   always_comb begin
      q_next = q_reg;
      if (clr) begin
         q_next = '0;
      end else if (inc && (q_reg != {W{1'b1}})) begin
         q_next = q_reg + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_reg <= '0;
      end else begin
         q_reg <= q_next;
      end
   end

   assign q = q_reg;

endmodule

// File: rtl/seq_detector_param.sv
// ----------------------------------------------------------------------------
// seq_detector_param
//
// Runtime-programmable serial bit-pattern detector with Mealy match output.
// The pattern (1..MAX_LEN bits), its length and the overlap mode are loaded
// through a config port; the block then watches a qualified serial stream.
//
// Parameters:
//   MAX_LEN  - maximum pattern length (must be >= 4)
//   CNT_W    - width of the saturating match counter
//   LEN_W    - width of length fields (derived)
//
// Ports:
//   clk          - clock, rising edge
//   reset        - synchronous, active-high
//   cfg_load     - capture cfg_pattern/cfg_len/cfg_overlap this cycle
//   cfg_pattern  - pattern; bit cfg_len-1 is received first, bit 0 last
//   cfg_len      - pattern length, legal 1..MAX_LEN
//   cfg_overlap  - 1 = overlapping matches, 0 = non-overlapping
//   d_valid      - d carries a stream bit this cycle
//   d            - serial data bit
//   match        - combinational match for the bit presented this cycle
//   match_cnt    - matches since reset/last legal load, saturating
//   cfg_err      - sticky flag: a load requested an illegal length
// ----------------------------------------------------------------------------
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter  int MAX_LEN = 8,
   parameter  int CNT_W   = 8,
   localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               d_valid,
   input  logic               d,
   output logic               match,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               cfg_err
);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [MAX_LEN-2:0] hist_reg,    hist_next;     // newest accepted bit in bit 0
   logic [LEN_W-1:0]   fill_reg,    fill_next;     // accepted bits, saturating
   logic [MAX_LEN-1:0] pat_reg,     pat_next;
   logic [LEN_W-1:0]   len_reg,     len_next;
   logic               ovl_reg,     ovl_next;
   logic               cfg_err_reg, cfg_err_next;

   // ------------------------------------------------------------------------
   // Window compare
   // ------------------------------------------------------------------------
   logic [MAX_LEN-1:0] window;
   logic [MAX_LEN-1:0] len_mask;
   logic               cfg_legal;
   logic               accept;
   logic               win_eq;
   logic               fill_ok;
   logic               match_int;
   logic               cnt_clr;

   assign cfg_legal = len_legal(int'(cfg_len), MAX_LEN);
   assign accept    = d_valid & ~cfg_load;

   // The full-width candidate always has d in bit 0; bits at or above len are
   // masked off, so history older than the pattern never affects the compare.
   assign window = {hist_reg, d};

   generate
      for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
         assign len_mask[gi] = (len_reg > LEN_W'(gi));
      end
   endgenerate

   assign win_eq = (((window ^ pat_reg) & len_mask) == '0);

   // At least len-1 bits must already be in history for the window to be
   // genuine; the compare is done one bit wider so len-1 never underflows.
   assign fill_ok = (({1'b0, fill_reg} + (LEN_W + 1)'(1)) >= {1'b0, len_reg});

   assign match_int = ~reset & accept & win_eq & fill_ok;

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      hist_next    = hist_reg;
      fill_next    = fill_reg;
      pat_next     = pat_reg;
      len_next     = len_reg;
      ovl_next     = ovl_reg;
      cfg_err_next = cfg_err_reg;

      if (cfg_load) begin
         if (cfg_legal) begin
            pat_next  = cfg_pattern;
            len_next  = cfg_len;
            ovl_next  = cfg_overlap;
            hist_next = '0;
            fill_next = '0;
         end else begin
            // Illegal length: keep the running configuration intact.
            cfg_err_next = 1'b1;
         end
      end else if (d_valid) begin
         hist_next = {hist_reg[MAX_LEN-3:0], d};
         if (match_int && !ovl_reg) begin
            // Non-overlapping: forget the matched window entirely.
            fill_next = '0;
         end else if (fill_reg != LEN_W'(MAX_LEN)) begin
            fill_next = fill_reg + LEN_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hist_reg    <= '0;
         fill_reg    <= '0;
         pat_reg     <= MAX_LEN'(DEF_PATTERN);
         len_reg     <= LEN_W'(DEF_LEN);
         ovl_reg     <= DEF_OVERLAP;
         cfg_err_reg <= 1'b0;
      end else begin
         hist_reg    <= hist_next;
         fill_reg    <= fill_next;
         pat_reg     <= pat_next;
         len_reg     <= len_next;
         ovl_reg     <= ovl_next;
         cfg_err_reg <= cfg_err_next;
      end
   end

   // ------------------------------------------------------------------------
   // Match counter: cleared only by a legal load (or reset)
   // ------------------------------------------------------------------------
   assign cnt_clr = cfg_load & cfg_legal;

   sat_counter #(
      .W (CNT_W)
   ) u_match_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .inc   (match_int),
      .q     (match_cnt)
   );

   assign match   = match_int;
   assign cfg_err = cfg_err_reg;

endmodule

// File: tb/tb_seq_detector_param.sv
// ----------------------------------------------------------------------------
// tb_seq_detector_param
//
// Drives two detector instances (8-bit and 2-bit match counters) with the same
// stimulus and compares them against a queue-based reference model: the model
// keeps the list of bits usable since the last restart and checks whether the
// newest len bits spell the pattern, first-received bit = pattern bit len-1.
// ----------------------------------------------------------------------------
module tb_seq_detector_param;

   localparam int MAX_LEN = 8;
   localparam int CNT_W   = 8;
   localparam int CNT2_W  = 2;
   localparam int LEN_W   = 4;
   localparam int CNT_MAX  = (1 << CNT_W) - 1;
   localparam int CNT2_MAX = (1 << CNT2_W) - 1;

   logic               clk = 1'b0;
   logic               reset;
   logic               cfg_load;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
   logic               d_valid;
   logic               d;
   logic               match, match2;
   logic [CNT_W-1:0]   match_cnt;
   logic [CNT2_W-1:0]  match_cnt2;
   logic               cfg_err, cfg_err2;

   always #5 clk = ~clk;

   seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
      .clk (clk), .reset (reset), .cfg_load (cfg_load), .cfg_pattern (cfg_pattern),
      .cfg_len (cfg_len), .cfg_overlap (cfg_overlap), .d_valid (d_valid), .d (d),
      .match (match), .match_cnt (match_cnt), .cfg_err (cfg_err)
   );

   seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT2_W)) dut2 (
      .clk (clk), .reset (reset), .cfg_load (cfg_load), .cfg_pattern (cfg_pattern),
      .cfg_len (cfg_len), .cfg_overlap (cfg_overlap), .d_valid (d_valid), .d (d),
      .match (match2), .match_cnt (match_cnt2), .cfg_err (cfg_err2)
   );

   // ------------------------------------------------------------------------
   // Checking
   // ------------------------------------------------------------------------
   int checks = 0;
   int errors = 0;
   int txn    = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s (txn %0d): got 0x%0h expected 0x%0h", tag, txn, got, exp);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------------
   bit                 seen[$];
   logic [MAX_LEN-1:0] pat_m;
   int                 len_m;
   bit                 ovl_m;
   int                 cnt_m, cnt2_m;
   bit                 err_m;

   function automatic bit model_match(input bit rst, input bit ld, input bit dv, input bit db);
      bit b;
      if (rst || ld || !dv) return 1'b0;
      if (seen.size() + 1 < len_m) return 1'b0;
      for (int k = 0; k < len_m; k++) begin
         b = (k == 0) ? db : seen[seen.size() - k];
         if (b != pat_m[k]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_update(input bit rst, input bit ld, input logic [MAX_LEN-1:0] p,
                               input int l, input bit o, input bit dv, input bit db,
                               input bit m);
      if (rst) begin
         pat_m = MAX_LEN'(4'b1010); len_m = 4; ovl_m = 1'b0;
         seen.delete(); cnt_m = 0; cnt2_m = 0; err_m = 1'b0;
      end else if (ld) begin
         if (l >= 1 && l <= MAX_LEN) begin
            pat_m = p; len_m = l; ovl_m = o;
            seen.delete(); cnt_m = 0; cnt2_m = 0;
         end else begin
            err_m = 1'b1;
         end
      end else if (dv) begin
         seen.push_back(db);
         if (seen.size() > MAX_LEN) void'(seen.pop_front());
         if (m) begin
            if (cnt_m  < CNT_MAX)  cnt_m++;
            if (cnt2_m < CNT2_MAX) cnt2_m++;
            if (!ovl_m) seen.delete();
         end
      end
   endtask

   // ------------------------------------------------------------------------
   // One clock cycle: drive, check match before the edge, check regs after
   // ------------------------------------------------------------------------
   task automatic cycle(input bit rst, input bit ld, input logic [MAX_LEN-1:0] p,
                        input logic [LEN_W-1:0] l, input bit o, input bit dv, input bit db,
                        output bit m_obs);
      bit exp_m;
      reset = rst; cfg_load = ld; cfg_pattern = p; cfg_len = l;
      cfg_overlap = o; d_valid = dv; d = db;
      exp_m = model_match(rst, ld, dv, db);
      @(negedge clk);
      check_val("match",  32'(match),  32'(exp_m));
      check_val("match2", 32'(match2), 32'(exp_m));
      m_obs = match;
      @(posedge clk);
      #1;
      model_update(rst, ld, p, int'(l), o, dv, db, exp_m);
      check_val("match_cnt",  32'(match_cnt),  32'(cnt_m));
      check_val("match_cnt2", 32'(match_cnt2), 32'(cnt2_m));
      check_val("cfg_err",    32'(cfg_err),    32'(err_m));
      check_val("cfg_err2",   32'(cfg_err2),   32'(err_m));
      $display("txn %0d rst=%0b ld=%0b pat=%02h len=%0d ovl=%0b dv=%0b d=%0b match=%0b cnt=%0d cnt2=%0d err=%0b",
               txn, rst, ld, p, l, o, dv, db, m_obs, match_cnt, match_cnt2, cfg_err);
      txn++;
   endtask

   task automatic bit_in(input bit db, output bit m);
      cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, db, m);
   endtask

   task automatic gap();
      bit m;
      cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, $urandom_range(0, 1) == 1, m);
   endtask

   task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input bit o);
      bit m;
      cycle(1'b0, 1'b1, p, l, o, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, m);
   endtask

   task automatic rst_cycle();
      bit m;
      cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, m);
   endtask

   // Feed n bits, MSB of bits first; hits[i] = match seen on the (i+1)-th bit.
   task automatic stream(input logic [31:0] bits, input int n, output logic [31:0] hits);
      bit m;
      hits = '0;
      for (int i = 0; i < n; i++) begin
         bit_in(bits[n-1-i], m);
         hits[i] = m;
      end
   endtask

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      logic [31:0] hits;
      bit          m;
      int          nm;
      int          ptr;
      int          r;
      int          exp_cnt2[5];

      exp_cnt2 = '{1, 2, 3, 3, 3};
      reset = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
      cfg_overlap = 1'b0; d_valid = 1'b0; d = 1'b0;
      @(posedge clk);
      #1;

      // Reset defaults
      rst_cycle();
      rst_cycle();
      check_val("rst_cnt", 32'(match_cnt), 32'd0);
      check_val("rst_err", 32'(cfg_err),   32'd0);

      // Default non-overlapping 1010: matches on bits 4 and 8
      stream(32'h2AA, 10, hits);
      check_val("def_hits", hits, 32'h088);
      check_val("def_cnt",  32'(match_cnt), 32'd2);

      // Overlapping 1010: matches on bits 4, 6, 8, 10
      load(8'b1010, 4'd4, 1'b1);
      stream(32'h2AA, 10, hits);
      check_val("ovl_hits", hits, 32'h2A8);
      check_val("ovl_cnt",  32'(match_cnt), 32'd4);

      // 111, overlap then non-overlap
      load(8'b111, 4'd3, 1'b1);
      stream(32'h1F, 5, hits);
      check_val("111o_hits", hits, 32'h1C);
      load(8'b111, 4'd3, 1'b0);
      stream(32'h1F, 5, hits);
      check_val("111n_hits", hits, 32'h04);
      check_val("111n_cnt",  32'(match_cnt), 32'd1);

      // Gaps inside 1010
      load(8'b1010, 4'd4, 1'b0);
      nm = 0;
      bit_in(1'b1, m); nm += int'(m); gap();
      bit_in(1'b0, m); nm += int'(m); gap(); gap();
      bit_in(1'b1, m); nm += int'(m); gap(); gap(); gap();
      bit_in(1'b0, m); nm += int'(m);
      check_val("gap_last", 32'(m), 32'd1);
      check_val("gap_nm",   32'(nm), 32'd1);

      // Illegal loads mid-pattern: config, progress and count survive
      bit_in(1'b1, m);
      bit_in(1'b0, m);
      load(8'hFF, 4'd0, 1'b1);
      check_val("err_len0", 32'(cfg_err), 32'd1);
      load(8'hFF, 4'(MAX_LEN + 1), 1'b1);
      bit_in(1'b1, m);
      bit_in(1'b0, m);
      check_val("err_match", 32'(m), 32'd1);
      check_val("err_cnt",   32'(match_cnt), 32'd2);
      stream(32'hA, 4, hits);
      check_val("err_hits", hits, 32'h8);
      check_val("err_sticky", 32'(cfg_err), 32'd1);

      // Narrow counter saturation
      rst_cycle();
      for (int i = 0; i < 5; i++) begin
         stream(32'hA, 4, hits);
         check_val($sformatf("sat_cnt2_%0d", i), 32'(match_cnt2), 32'(exp_cnt2[i]));
      end
      check_val("sat_cnt8", 32'(match_cnt), 32'd5);

      // Reset mid-pattern discards progress and any loaded pattern
      load(8'h00, 4'd1, 1'b1);
      stream(32'h5, 3, hits);
      rst_cycle();
      bit_in(1'b0, m);
      check_val("midrst_match", 32'(m), 32'd0);
      check_val("midrst_cnt",   32'(match_cnt), 32'd0);

      // Randomized traffic, d biased toward the active pattern
      ptr = len_m - 1;
      for (int i = 0; i < 1500; i++) begin
         r = int'($urandom_range(0, 199));
         if (r < 1) begin
            rst_cycle();
         end else if (r < 6) begin
            load(8'($urandom), 4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);
         end else if (r < 60) begin
            gap();
         end else begin
            if (ptr >= len_m || ptr < 0) ptr = len_m - 1;
            if ($urandom_range(0, 4) == 0) begin
               bit_in($urandom_range(0, 1) == 1, m);
            end else begin
               bit_in(pat_m[ptr], m);
               ptr = (ptr == 0) ? len_m - 1 : ptr - 1;
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
